// File: rtl/platform_pkg.sv
// Platform-wide constants and types shared by the serial blocks.
package platform_pkg;

  localparam int CLKS_PER_BAUD  = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO. The head entry is visible on rdata whenever the
// FIFO is non-empty. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_POT  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_POT:0]    count
);

  localparam logic [DEPTH_POT:0] DEPTH = (DEPTH_POT+1)'(1) << DEPTH_POT;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_POT];
  logic [DEPTH_POT-1:0]  wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count as is.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Bytes queue in a sync_fifo; the baud FSM
// drains it and emits frames back-to-back while data remains queued.
module uart_tx_buffered #(
  parameter int CLKS_PER_BAUD  = platform_pkg::CLKS_PER_BAUD,
  parameter int FIFO_DEPTH_POT = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              wdata_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [FIFO_DEPTH_POT:0] fifo_count_o,
  output logic                    busy_o,
  output logic                    uart_tx_o
);

  import platform_pkg::*;

  localparam int CNT_W = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BAUD - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tx;
  logic             fifo_full, fifo_empty, fifo_pop, baud_term;
  logic [7:0]       fifo_rdata;

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_POT  (FIFO_DEPTH_POT)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (wvalid_i),
    .pop     (fifo_pop),
    .wdata   (wdata_i),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_o)
  );

  assign baud_term = (baud_cnt == BAUD_LAST);
  assign wready_o  = !fifo_full;
  assign busy_o    = (state != IDLE) || !fifo_empty;
  assign uart_tx_o = tx;

  // A new frame is fetched from idle, or straight out of a finished stop bit.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)                  fifo_pop = 1'b1;
      else if (state == STOP && baud_term) fifo_pop = 1'b1;
    end
  end

  // Baud FSM: each bit lasts CLKS_PER_BAUD cycles, data shifts out LSB first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      if (state != IDLE) baud_cnt <= baud_term ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shreg    <= fifo_rdata;
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: if (baud_term) begin
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (baud_term) begin
          if (bit_idx == BIT_LAST) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: if (baud_term) begin
          if (fifo_pop) begin
            shreg <= fifo_rdata;
            tx    <= 1'b0;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
